// File: rtl/aes_inv_shift_mix.sv
// aes_inv_shift_mix: multi-cycle AES decryption round helper.
// Applies InvShiftRows at capture, then InvMixColumns one column per cycle.
// The skip_mix_i path (final round) bypasses InvMixColumns.
// Optional macro AES_INV_PIPE_ACCEPT_EN lets a new block be accepted on the
// same edge that the finished block retires.
module aes_inv_shift_mix (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
  input  logic         skip_mix_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o,
  output logic         busy_o
);

  // Fixed at 4; only sizes the column counter.
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned ColW     = $clog2(NUM_COLS);

  // Element NUM_COLS-1 holds the MSBs, i.e. column 0.
  typedef logic [NUM_COLS-1:0][31:0] state_t;

  typedef enum logic [1:0] {StIdle, StBusy, StSkip, StDone} state_e;

  state_e          state_q;
  logic [ColW-1:0] col_q;
  state_t          shift_q;
  state_t          out_q;
  logic [127:0]    shifted;
  logic            accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column using xtime chains: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      b[k]  = col[31-8*k -: 8];
      x2[k] = xtime(b[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m9[k] = x8[k] ^ b[k];
      mb[k] = x8[k] ^ x2[k] ^ b[k];
      md[k] = x8[k] ^ x4[k] ^ b[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(r+4*c) -: 8] = in_state_i[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
  end

  // Input handshake readiness; pipelined build also accepts while retiring in DONE.
  always_comb begin
    in_ready_o = (state_q == StIdle);
`ifdef AES_INV_PIPE_ACCEPT_EN
    if (state_q == StDone) in_ready_o = out_ready_i;
`endif
  end

  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StBusy);
  assign out_state_o = out_q;

  // Control FSM and datapath registers; a capture takes priority over retiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
    end else if (accept) begin
      shift_q <= shifted;
      col_q   <= '0;
      state_q <= skip_mix_i ? StSkip : StBusy;
    end else begin
      case (state_q)
        StIdle: ;
        StBusy: begin
          // With 4 columns, ~col_q == NUM_COLS-1-col_q selects column col_q.
          out_q[~col_q] <= inv_mix_col(shift_q[~col_q]);
          col_q         <= col_q + 1'b1;
          if (col_q == ColW'(NUM_COLS - 1)) state_q <= StDone;
        end
        // Skip path presents the shifted state one edge after capture.
        StSkip: begin
          out_q   <= shift_q;
          state_q <= StDone;
        end
        StDone: if (out_ready_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_shift_mix.sv
// Self-checking bench for aes_inv_shift_mix with a byte-level reference model.
module tb_aes_inv_shift_mix;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         skip_mix;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks;
  int failures;

  aes_inv_shift_mix dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_state_i  (in_state),
    .skip_mix_i  (skip_mix),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_state_o (out_state),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din, input logic skip);
    logic [7:0]   b    [16];
    logic [7:0]   s    [16];
    logic [7:0]   o    [16];
    logic [7:0]   coef [4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) b[i] = din[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r+4*c] = b[r+4*((c-r+4)%4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[r+4*c] = 8'h00;
        for (int k = 0; k < 4; k++) o[r+4*c] = o[r+4*c] ^ gmul(coef[(k-r+4)%4], s[k+4*c]);
      end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = skip ? s[i] : o[i];
    return res;
  endfunction

  // Send one block from IDLE, return result, latency (edges after accept) and busy samples.
  task automatic run_block(input logic [127:0] data, input logic skip, input int stall,
                           output logic [127:0] res, output int lat, output int bcnt);
    lat = -1; bcnt = 0; res = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_state = data; skip_mix = skip;
    @(posedge clk); #1;
    in_valid = 1'b0; in_state = rand128(); skip_mix = 1'($urandom_range(0, 1));
    if (busy) bcnt++;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = t; break; end
      if (busy) bcnt++;
    end
    if (lat > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      res = out_state;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (out_state !== '0) begin failures++; $display("FAIL rst_out_state got=%h exp=0", out_state); end
  endtask

  task automatic test_vectors();
    logic [127:0] din [4];
    logic [127:0] exp [4];
    logic         skp [4];
    logic [127:0] res;
    int lat, bcnt;
    din[0] = 128'h000102030405060708090a0b0c0d0e0f; skp[0] = 1'b1;
    exp[0] = 128'h000d0a07_04010e0b_0805020f_0c090603;
    din[1] = {4{32'h8e4da1bc}}; skp[1] = 1'b0; exp[1] = {4{32'hdb135345}};
    din[2] = {4{32'h9fdc589d}}; skp[2] = 1'b0; exp[2] = {4{32'hf20a225c}};
    din[3] = {4{32'h01010101}}; skp[3] = 1'b0; exp[3] = {4{32'h01010101}};
    for (int i = 0; i < 4; i++) begin
      run_block(din[i], skp[i], 0, res, lat, bcnt);
      checks++;
      if (res !== exp[i]) begin
        failures++; $display("FAIL vec%0d_result got=%h exp=%h", i, res, exp[i]);
      end
      checks++;
      if (lat != (skp[i] ? 1 : 4)) begin
        failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, skp[i] ? 1 : 4);
      end
      checks++;
      if (bcnt != (skp[i] ? 0 : 4)) begin
        failures++; $display("FAIL vec%0d_busy_cycles got=%0d exp=%0d", i, bcnt, skp[i] ? 0 : 4);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] din, res, exp;
    logic skp;
    int lat, bcnt;
    for (int i = 0; i < 20; i++) begin
      din = rand128(); skp = 1'($urandom_range(0, 1));
      exp = model(din, skp);
      run_block(din, skp, int'($urandom_range(0, 2)), res, lat, bcnt);
      checks++;
      if (res !== exp) begin failures++; $display("FAIL rand%0d_result got=%h exp=%h", i, res, exp); end
      checks++;
      if (lat != (skp ? 1 : 4)) begin
        failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, skp ? 1 : 4);
      end
      checks++;
      if (bcnt != (skp ? 0 : 4)) begin
        failures++; $display("FAIL rand%0d_busy_cycles got=%0d exp=%0d", i, bcnt, skp ? 0 : 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] din, held, exp;
    int t;
    bit stray;
    din = rand128(); exp = model(din, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_state = din; skip_mix = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
    held = out_state;
    checks++;
    if (held !== exp) begin failures++; $display("FAIL bp_result got=%h exp=%h", held, exp); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_state = rand128(); skip_mix = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_state !== held || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b r%b %h exp=v1 r0 %h", i, out_valid, in_ready, out_state, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got=v%b r%b b%b exp=v0 r1 b0", out_valid, in_ready, busy);
    end
    stray = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (out_valid || busy) stray = 1'b1; end
    checks++;
    if (stray) begin failures++; $display("FAIL bp_ignored_pulse got=1 exp=0"); end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] din, res, exp;
    int lat, bcnt;
    bit stray;
    @(posedge clk); #1;
    in_valid = 1'b1; in_state = rand128(); skip_mix = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (out_valid || busy) stray = 1'b1; end
    checks++;
    if (stray) begin failures++; $display("FAIL mid_busy_partial_output got=1 exp=0"); end
    din = rand128(); exp = model(din, 1'b0);
    run_block(din, 1'b0, 0, res, lat, bcnt);
    checks++;
    if (res !== exp || lat != 4) begin
      failures++; $display("FAIL mid_busy_after got=%h lat=%0d exp=%h lat=4", res, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, ra, rb;
    int ta, tb, exp_gap;
    bit acc, seen_low;
`ifdef AES_INV_PIPE_ACCEPT_EN
    exp_gap = 5;
`else
    exp_gap = 6;
`endif
    a = rand128(); b = rand128();
    ta = -1; tb = -1; ra = '0; rb = '0; seen_low = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_state = a; skip_mix = 1'b0;
    @(posedge clk); #1;
    in_state = b;
    for (int t = 1; t <= 30; t++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      if (out_valid && ta < 0) begin ta = t; ra = out_state; end
      else if (!out_valid && ta >= 0) seen_low = 1'b1;
      else if (out_valid && seen_low) begin tb = t; rb = out_state; break; end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (ra !== model(a, 1'b0)) begin failures++; $display("FAIL b2b_first got=%h exp=%h", ra, model(a, 1'b0)); end
    checks++;
    if (rb !== model(b, 1'b0)) begin failures++; $display("FAIL b2b_second got=%h exp=%h", rb, model(b, 1'b0)); end
    checks++;
    if (tb < 0 || ta < 0 || tb - ta != exp_gap) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=%0d", tb - ta, exp_gap);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; skip_mix = 1'b0; out_ready = 1'b0;
    #3;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_shift_mix.md
Name: aes_inv_shift_mix

Overview:
Multi-cycle decryption-side AES round helper. It applies InvShiftRows and then InvMixColumns to a 128-bit state, computing one column per cycle. It sits in the inverse-cipher round loop, between the InvSubBytes/AddRoundKey stages, and uses valid/ready handshakes on both sides. A per-block skip_mix input bypasses InvMixColumns for the final round.

Parameters:
NUM_COLS, 4, columns per state; fixed at 4 and not legal to override; used for counter sizing only

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_state/skip_mix valid
in_ready  output  1  block can accept a state
in_state  input  128  state; byte i = in_state[127-8i -: 8], column-major (byte r+4c = row r, column c)
skip_mix  input  1  1 = InvShiftRows only (last round); sampled with the input handshake
out_valid  output  1  out_state valid
out_ready  input  1  downstream accepts out_state
out_state  output  128  result, same byte order as in_state
busy  output  1  high in BUSY state

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, busy=0, out_state=0, column counter=0, internal state registers=0.
- InvShiftRows is applied combinationally at capture: shifted[r+4c] = in[r+4((c-r) mod 4)], so row r rotates right by r.
- InvMixColumns per column (b0..b3) in GF(2^8), polynomial 0x11b:
  - o0 = 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3; remaining rows use the same coefficients rotated right by one per row.
  - Implemented with xtime chains; no multipliers and no lookup tables.
- FSM IDLE:
  - in_ready=1.
  - On in_valid: capture the shifted state and skip_mix.
  - skip_mix=0: go to BUSY with col=0.
  - skip_mix=1: load out_state=shifted and go to DONE.
- FSM BUSY:
  - in_ready=0, busy=1.
  - Each cycle, write InvMixColumns(column col) into out_state column col, then col++.
  - After col=3, go to DONE.
- FSM DONE:
  - out_valid=1; out_state is held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid drops and the FSM goes to IDLE.
- Latency, counted in clock edges after the accepting edge:
  - skip_mix=0: out_valid rises after 4 edges.
  - skip_mix=1: out_valid rises after 1 edge.
  - Throughput (base build): one block per 6 cycles (mix) or 3 cycles (skip), with out_ready held high.
- in_valid while in_ready=0 is ignored. The upstream stage must hold in_valid and its data until in_ready=1.
- Changing in_state or skip_mix while not accepted has no effect.
- rst_n asserted mid-BUSY or mid-DONE aborts the block immediately: all outputs return to their reset values and no partial output is emitted.
- out_state columns not yet written in BUSY hold their previous values. They are not observable because out_valid=0.

Optional Feature:
- Macro: AES_INV_PIPE_ACCEPT_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - A simultaneous in_valid & out_ready in DONE retires the current block and captures the new one on the same edge.
  - The FSM then goes directly to BUSY (or DONE if the new skip_mix=1), skipping IDLE.
  - Throughput becomes one block per 5 cycles (mix).
- Undefined: in_ready=0 in DONE; IDLE is always visited between blocks.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY -> in_ready=1, out_valid=0, busy=0, out_state=0 immediately. After release, next input is processed normally.
- skip_mix=1, in_state=000102030405060708090a0b0c0d0e0f -> after 1 edge, out_valid=1, out_state=000d0a07_04010e0b_0805020f_0c090603.
- skip_mix=0, in_state = 8e4da1bc repeated 4 times -> busy high for 4 cycles, then out_state = db135345 repeated 4 times.
- skip_mix=0:
  - in_state = 9fdc589d repeated 4 times -> out_state = f20a225c ×4.
  - in_state = 01010101 ×4 -> out_state unchanged.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable; in_ready=0; in_valid pulses ignored. Then out_ready=1 for 1 cycle -> IDLE.
- With AES_INV_PIPE_ACCEPT_EN: two back-to-back mix blocks with out_ready=1 -> second accepted on the same edge the first retires; second out_valid occurs 5 cycles after the first.
